dsp_capture_reader: RTL and testbench

//  Reader end of the ce-strobed DSP sample stream produced by the down/upsampler filters.

---
 rtl/dsp_capture_pkg.sv | 14 +
 rtl/dsp_capture_reader_if.sv | 14 +
 rtl/capture_ram.sv | 25 ++
 rtl/dsp_capture_reader.sv | 135 +++++++++++++
 tb/tb_dsp_capture_reader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_capture_pkg.sv
// Shared types and default sizes for the DSP capture reader.
package dsp_capture_pkg;

   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_DEPTH_LOG2 = 10;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      READOUT
   } state_t;

endpackage

// File: rtl/dsp_capture_reader_if.sv
// Playback stream (valid/ready) carrying captured samples to the host readout path.
interface dsp_capture_reader_if #(
   parameter int unsigned DATA_W = 16
) ();

   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              rd_ready;

   modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
   modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module capture_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port plus registered read; read output holds when rd_en is low.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/dsp_capture_reader.sv
// Triggered capture of the ce-strobed DSP sample stream with valid/ready playback.
module dsp_capture_reader
   import dsp_capture_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
   input  logic                     sys_clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_ce,
   input  logic                     arm,
   input  logic signed [DATA_W-1:0] trig_level,
   input  logic                     trig_force,
   dsp_capture_reader_if.master     rd,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned           CNT_W     = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;
   localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'((1 << DEPTH_LOG2) - 1);

   state_t                   state_q, state_d;
   logic [DEPTH_LOG2-1:0]    wr_addr_q, wr_addr_sel;
   logic [CNT_W-1:0]         rd_cnt_q;
   logic signed [DATA_W-1:0] prev_q;
   logic                     prev_vld_q, force_q;
   logic                     pipe_vld_q, pipe_last_q;
   logic [DATA_W-1:0]        ram_q;
   logic                     trig_hit, wr_en, advance, issue, last_hs;

   // Next state, trigger detect and readout pipeline control.
   always_comb begin
      state_d     = state_q;
      wr_en       = 1'b0;
      wr_addr_sel = wr_addr_q;
      trig_hit    = sample_ce && (force_q || trig_force ||
                    (prev_vld_q && (prev_q < trig_level) && (sample_in >= trig_level)));
      advance     = !rd.rd_valid || rd.rd_ready;
      issue       = (state_q == READOUT) && advance && !rd_cnt_q[CNT_W-1];
      last_hs     = rd.rd_valid && rd.rd_ready && rd.rd_last;
      unique case (state_q)
         IDLE:    if (arm) state_d = ARMED;
         ARMED: begin
            if (trig_hit) begin
               wr_en       = 1'b1;
               wr_addr_sel = '0;
               state_d     = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sample_ce) begin
               wr_en = 1'b1;
               if (wr_addr_q == LAST_ADDR) state_d = READOUT;
            end
         end
         READOUT: if (last_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Previous-sample tracking and sticky force flag while waiting for a trigger.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         force_q    <= 1'b0;
      end else if (state_q == IDLE) begin
         prev_vld_q <= 1'b0;
         force_q    <= arm && trig_force;
      end else if (state_q == ARMED) begin
         if (sample_ce) begin
            prev_q     <= sample_in;
            prev_vld_q <= 1'b1;
         end
         force_q <= (force_q || trig_force) && !trig_hit;
      end
   end

   // Capture write address; trigger sample lands at 0, the rest follow in order.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset)                  wr_addr_q <= '0;
      else if (state_q == IDLE)   wr_addr_q <= '0;
      else if (wr_en)             wr_addr_q <= DEPTH_LOG2'(wr_addr_sel + 1'b1);
   end

   // Two-stage playback pipe (RAM read register, output register) that stalls as one.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         rd_cnt_q    <= '0;
         pipe_vld_q  <= 1'b0;
         pipe_last_q <= 1'b0;
         rd.rd_data  <= '0;
         rd.rd_valid <= 1'b0;
         rd.rd_last  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy <= (state_d != IDLE);
         done <= (state_q == READOUT) && last_hs;
         if (state_q != READOUT) begin
            rd_cnt_q   <= '0;
            pipe_vld_q <= 1'b0;
         end else if (advance) begin
            if (pipe_vld_q) rd.rd_data <= ram_q;
            rd.rd_valid <= pipe_vld_q;
            rd.rd_last  <= pipe_vld_q && pipe_last_q;
            pipe_vld_q  <= issue;
            pipe_last_q <= issue && (rd_cnt_q == LAST_CNT);
            if (issue) rd_cnt_q <= CNT_W'(rd_cnt_q + 1'b1);
         end
      end
   end

   capture_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk     (sys_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr_sel),
      .wr_data (sample_in),
      .rd_en   (issue),
      .rd_addr (rd_cnt_q[DEPTH_LOG2-1:0]),
      .rd_data (ram_q)
   );

endmodule

// File: tb/tb_dsp_capture_reader.sv
// Directed bench for dsp_capture_reader: ramp, forced, full-scale and reset-abort captures.
module tb_dsp_capture_reader;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned DEPTH_LOG2 = 6;
   localparam int          DEPTH      = 64;

   logic                     sys_clk;
   logic                     reset;
   logic signed [DATA_W-1:0] sample_in;
   logic                     sample_ce;
   logic                     arm;
   logic signed [DATA_W-1:0] trig_level;
   logic                     trig_force;
   logic                     busy;
   logic                     done;

   dsp_capture_reader_if #(.DATA_W(DATA_W)) rdif ();

   dsp_capture_reader #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .sample_in  (sample_in),
      .sample_ce  (sample_ce),
      .arm        (arm),
      .trig_level (trig_level),
      .trig_force (trig_force),
      .rd         (rdif),
      .busy       (busy),
      .done       (done)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;

   int       cyc, gen_val, gen_mode, last_sent;
   int       n_done, n_last, last_idx, first_hs, last_hs_cyc;
   int       held_data, held_last;
   logic     gen_on, rnd_ready, stalled;
   logic [1:0] gen_phase;
   int       got_q[$];
   int       exp_a[DEPTH];

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_capture();
      got_q.delete();
      n_done   = 0;
      n_last   = 0;
      last_idx = -1;
      first_hs = 0;
      last_hs_cyc = 0;
   endtask

   // One clock: drive generator/consumer, record handshakes, then advance past the edge.
   task automatic step();
      logic hs;
      sample_ce = gen_on && (gen_phase == 2'd3);
      if (sample_ce) sample_in = 16'(gen_val);
      rdif.rd_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (stalled) begin
         check("stall_valid", 32'(rdif.rd_valid), 1);
         check("stall_data", 32'($signed(rdif.rd_data)), held_data);
         check("stall_last", 32'(rdif.rd_last), held_last);
      end
      hs = rdif.rd_valid && rdif.rd_ready;
      if (hs) begin
         if (got_q.size() == 0) first_hs = cyc;
         last_hs_cyc = cyc;
         got_q.push_back(32'($signed(rdif.rd_data)));
         if (rdif.rd_last) begin
            n_last++;
            last_idx = got_q.size() - 1;
         end
      end
      stalled   = rdif.rd_valid && !rdif.rd_ready;
      held_data = 32'($signed(rdif.rd_data));
      held_last = 32'(rdif.rd_last);
      @(posedge sys_clk);
      #1;
      cyc++;
      if (sample_ce) begin
         last_sent = gen_val;
         if (gen_mode == 1) begin
            if (gen_val < 1000) gen_val++;
            else gen_on = 1'b0;
         end else if (gen_mode == 2) begin
            gen_val = (gen_val == -32768) ? 32767 : -32768;
         end
      end
      gen_phase++;
      if (done) begin
         n_done++;
         check("done_busy", 32'(busy), 0);
         check("done_valid", 32'(rdif.rd_valid), 0);
      end
      arm        = 1'b0;
      trig_force = 1'b0;
   endtask

   task automatic wait_sent(input int val, input int budget);
      int n = 0;
      while (last_sent != val && n < budget) begin
         step();
         n++;
      end
      check("wait_sent", last_sent, val);
   endtask

   task automatic run_done(input int budget);
      int n = 0;
      while (n_done == 0 && n < budget) begin
         step();
         n++;
      end
      check("done_seen", n_done, 1);
      repeat (3) step();
      check("done_once", n_done, 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_valid", 32'(rdif.rd_valid), 0);
   endtask

   task automatic verify(input string tag);
      check({tag, "_count"}, got_q.size(), DEPTH);
      for (int k = 0; k < DEPTH; k++) begin
         if (k < got_q.size()) check($sformatf("%s[%0d]", tag, k), got_q[k], exp_a[k]);
      end
      check({tag, "_last_idx"}, last_idx, DEPTH - 1);
      check({tag, "_last_cnt"}, n_last, 1);
   endtask

   initial begin
      int n;
      reset = 1'b1; arm = 1'b0; trig_force = 1'b0; sample_ce = 1'b0; sample_in = '0;
      trig_level = '0; rdif.rd_ready = 1'b0;
      gen_on = 1'b0; gen_mode = 0; gen_val = 0; gen_phase = '0; last_sent = 99999;
      rnd_ready = 1'b0; stalled = 1'b0; held_data = 0; held_last = 0; cyc = 0;
      clear_capture();

      // Reset state
      repeat (3) step();
      check("rst_data", 32'(rdif.rd_data), 0);
      check("rst_valid", 32'(rdif.rd_valid), 0);
      check("rst_last", 32'(rdif.rd_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      reset = 1'b0;
      repeat (2) step();

      // Ramp through level 0, arm pulses during capture and readout are ignored
      trig_level = 16'sd0; gen_mode = 1; gen_val = -1000; gen_phase = '0; gen_on = 1'b1;
      for (int k = 0; k < DEPTH; k++) exp_a[k] = k;
      clear_capture();
      repeat (8) step();
      arm = 1'b1; step();
      check("arm_busy", 32'(busy), 1);
      wait_sent(10, 6000);
      arm = 1'b1; step();
      wait_sent(63, 1000);
      check("ro_valid_e0", 32'(rdif.rd_valid), 0);
      step();
      check("ro_valid_e1", 32'(rdif.rd_valid), 0);
      step();
      check("ro_valid_e2", 32'(rdif.rd_valid), 1);
      check("ro_data_e2", 32'($signed(rdif.rd_data)), 0);
      n = 0;
      while (got_q.size() < 5 && n < 100) begin
         step();
         n++;
      end
      arm = 1'b1; step();
      run_done(200);
      verify("ramp");
      check("zero_bubble", last_hs_cyc - first_hs, DEPTH - 1);

      // Reset in the middle of a capture, then a full re-capture with a throttled consumer
      gen_val = -1000; gen_phase = '0; gen_on = 1'b1;
      clear_capture();
      arm = 1'b1; step();
      wait_sent(36, 6000);
      reset = 1'b1; step();
      check("abort_data", 32'(rdif.rd_data), 0);
      check("abort_valid", 32'(rdif.rd_valid), 0);
      check("abort_last", 32'(rdif.rd_last), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_no_data", got_q.size(), 0);
      reset = 1'b0; step();
      gen_val = -1000; gen_phase = '0; gen_on = 1'b1; rnd_ready = 1'b1;
      clear_capture();
      arm = 1'b1; step();
      wait_sent(63, 6000);
      run_done(2000);
      verify("rerun_rnd");
      rnd_ready = 1'b0;

      // Constant input above level never triggers; force then captures it
      gen_mode = 0; gen_val = 500; trig_level = 16'sd0;
      for (int k = 0; k < DEPTH; k++) exp_a[k] = 500;
      clear_capture();
      arm = 1'b1; step();
      repeat (10000) step();
      check("const_busy", 32'(busy), 1);
      check("const_no_data", got_q.size(), 0);
      check("const_no_done", n_done, 0);
      trig_force = 1'b1; step();
      run_done(1000);
      verify("const_force");

      // Full-scale crossing onto the maximum level
      gen_mode = 2; gen_val = -32768; trig_level = 16'sh7fff;
      for (int k = 0; k < DEPTH; k++) exp_a[k] = (k % 2 == 0) ? 32767 : -32768;
      clear_capture();
      arm = 1'b1; step();
      run_done(1000);
      verify("fullscale");

      // Minimum level with input pinned at minimum never crosses
      gen_mode = 0; gen_val = -32768; trig_level = 16'sh8000;
      for (int k = 0; k < DEPTH; k++) exp_a[k] = -32768;
      clear_capture();
      arm = 1'b1; step();
      repeat (2000) step();
      check("pinned_busy", 32'(busy), 1);
      check("pinned_no_data", got_q.size(), 0);
      trig_force = 1'b1; step();
      run_done(1000);
      verify("pinned_force");

      // Arm and force together from idle: first strobe triggers
      gen_val = 123; trig_level = 16'sd0;
      for (int k = 0; k < DEPTH; k++) exp_a[k] = 123;
      clear_capture();
      arm = 1'b1; trig_force = 1'b1; step();
      run_done(1000);
      verify("arm_force");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
